// File: rtl/pc_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch front end and imem.
// master = fetch side (drives req/addr), slave = memory side (drives ack/rdata).
interface pc_fetch_if;
   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic [31:0] rdata;

   modport master (output req, output addr, input ack, input rdata);
   modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/pc_fetch.sv
// PC register and req/ack instruction-fetch front end of the single-cycle MIPS datapath.
// Optional macro PC_ALIGN_CHECK_EN: word-align committed targets and raise sticky o_misalign.
module pc_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_dir,
   input  logic        i_stall,
   pc_fetch_if.master  imem,
   output logic [31:0] o_pc_next,
   output logic [31:0] o_instr,
   output logic [25:0] o_inm26,
   output logic [15:0] o_inm16,
   output logic        o_instr_valid,
   output logic        o_misalign
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic [31:0] w_pc_load;
   logic        w_req;
   logic        w_valid;
   logic        w_commit;
   logic        w_capture;

   assign w_capture = (r_state == S_REQ) && imem.ack;
   assign w_commit  = (r_state == S_HOLD) && !i_stall;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  w_state_nxt = S_REQ;
         S_REQ:   if (imem.ack) w_state_nxt = S_HOLD;
         S_HOLD:  if (!i_stall) w_state_nxt = S_REQ;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_req   = 1'b0;
      w_valid = 1'b0;
      case (r_state)
         S_REQ:   w_req   = 1'b1;
         S_HOLD:  w_valid = 1'b1;
         default: begin
            w_req   = 1'b0;
            w_valid = 1'b0;
         end
      endcase
   end

`ifdef PC_ALIGN_CHECK_EN
   logic r_misalign;

   assign w_pc_load = {i_dir[31:2], 2'b00};

   // Sticky until reset: once a bad target has been seen it stays reported.
   always_ff @(posedge i_clk) begin
      if (i_rst)                       r_misalign <= 1'b0;
      else if (w_commit && |i_dir[1:0]) r_misalign <= 1'b1;
   end

   assign o_misalign = r_misalign;
`else
   assign w_pc_load  = i_dir;
   assign o_misalign = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst)         r_pc <= RESET_PC;
      else if (w_commit) r_pc <= w_pc_load;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)          r_instr <= 32'h0000_0000;
      else if (w_capture) r_instr <= imem.rdata;
   end

   assign imem.req      = w_req;
   assign imem.addr     = r_pc;
   assign o_pc_next     = r_pc + 32'd4;
   assign o_instr       = r_instr;
   assign o_inm26       = r_instr[25:0];
   assign o_inm16       = r_instr[15:0];
   assign o_instr_valid = w_valid;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed vector table through reset/fetch/stall/wrap/misalign,
// then randomized req/ack/stall/reset traffic against a transaction-level model.
module tb_pc_fetch;
   localparam logic [31:0] RST_PC = 32'h0040_0000;
`ifdef PC_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] dir;
   logic        stall;
   logic [31:0] pc_next, instr;
   logic [25:0] inm26;
   logic [15:0] inm16;
   logic        instr_valid, misalign;

   int n_vec = 0;
   int n_err = 0;

   pc_fetch_if u_if ();

   pc_fetch #(.RESET_PC(RST_PC)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_dir        (dir),
      .i_stall      (stall),
      .imem         (u_if),
      .o_pc_next    (pc_next),
      .o_instr      (instr),
      .o_inm26      (inm26),
      .o_inm16      (inm16),
      .o_instr_valid(instr_valid),
      .o_misalign   (misalign)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, ack, stall;
      logic [31:0] dir, rdata;
      logic        e_req, e_vld;
      logic [31:0] e_addr, e_instr;
      logic        e_mis;
   } vec_t;

   function automatic vec_t mk(logic r, logic a, logic s, logic [31:0] d, logic [31:0] rd,
                               logic eq, logic ev, logic [31:0] ea, logic [31:0] ei, logic em);
      vec_t v;
      v.rst = r; v.ack = a; v.stall = s; v.dir = d; v.rdata = rd;
      v.e_req = eq; v.e_vld = ev; v.e_addr = ea; v.e_instr = ei; v.e_mis = em;
      return v;
   endfunction

   task automatic check(string name, logic eq, logic ev, logic [31:0] ea, logic [31:0] ei, logic em);
      logic [31:0] en;
      logic [25:0] e26;
      logic [15:0] e16;
      en  = ea + 32'd4;
      e26 = ei[25:0];
      e16 = ei[15:0];
      n_vec++;
      if (u_if.req !== eq || instr_valid !== ev || u_if.addr !== ea || pc_next !== en ||
          instr !== ei || inm26 !== e26 || inm16 !== e16 || misalign !== em) begin
         n_err++;
         $display("FAIL %s: got req=%b vld=%b addr=%h next=%h instr=%h i26=%h i16=%h mis=%b; want req=%b vld=%b addr=%h next=%h instr=%h i26=%h i16=%h mis=%b",
                  name, u_if.req, instr_valid, u_if.addr, pc_next, instr, inm26, inm16, misalign,
                  eq, ev, ea, en, ei, e26, e16, em);
      end
   endtask

   // Reference model: "booting" = first cycle after reset, "have" = a fetched word belongs to pc.
   logic [31:0] m_pc, m_instr;
   logic        m_mis, m_boot, m_have;

   task automatic model_edge();
      if (rst) begin
         m_pc = RST_PC; m_instr = 0; m_mis = 0; m_boot = 1; m_have = 0;
      end else if (m_boot) begin
         m_boot = 0;
      end else if (!m_have) begin
         if (u_if.ack) begin
            m_instr = u_if.rdata;
            m_have  = 1;
         end
      end else if (!stall) begin
         m_pc   = ALIGN ? (dir & ~32'd3) : dir;
         m_mis  = m_mis | (ALIGN && (dir[1:0] != 2'b00));
         m_have = 0;
      end
   endtask

   vec_t tbl[23];

   initial begin
      logic [31:0] a20;
      a20 = ALIGN ? 32'h0040_0004 : 32'h0040_0006;

      //           rst ack stl dir            rdata          req vld addr           instr          mis
      tbl[0]  = mk(1, 0, 0, 32'h0,          32'h0,          0, 0, 32'h0040_0000, 32'h0,          0);
      tbl[1]  = mk(1, 1, 0, 32'h0,          32'h1111_1111,  0, 0, 32'h0040_0000, 32'h0,          0);
      tbl[2]  = mk(0, 0, 0, 32'h0,          32'h0,          1, 0, 32'h0040_0000, 32'h0,          0);
      tbl[3]  = mk(0, 1, 0, 32'h0,          32'h0810_0004,  0, 1, 32'h0040_0000, 32'h0810_0004,  0);
      tbl[4]  = mk(0, 0, 0, 32'h0040_0004,  32'h0,          1, 0, 32'h0040_0004, 32'h0810_0004,  0);
      tbl[5]  = mk(0, 0, 1, 32'h0,          32'h0,          1, 0, 32'h0040_0004, 32'h0810_0004,  0);
      tbl[6]  = mk(0, 0, 0, 32'h0,          32'h0,          1, 0, 32'h0040_0004, 32'h0810_0004,  0);
      tbl[7]  = mk(0, 0, 1, 32'h0,          32'h0,          1, 0, 32'h0040_0004, 32'h0810_0004,  0);
      tbl[8]  = mk(0, 1, 0, 32'h0,          32'hAABB_CCDD,  0, 1, 32'h0040_0004, 32'hAABB_CCDD,  0);
      tbl[9]  = mk(0, 1, 1, 32'h1111_1110,  32'h5555_5555,  0, 1, 32'h0040_0004, 32'hAABB_CCDD,  0);
      tbl[10] = mk(0, 0, 1, 32'h2222_2220,  32'h0,          0, 1, 32'h0040_0004, 32'hAABB_CCDD,  0);
      tbl[11] = mk(0, 1, 1, 32'h3333_3330,  32'h6666_6666,  0, 1, 32'h0040_0004, 32'hAABB_CCDD,  0);
      tbl[12] = mk(0, 0, 1, 32'h4444_4440,  32'h0,          0, 1, 32'h0040_0004, 32'hAABB_CCDD,  0);
      tbl[13] = mk(0, 0, 0, 32'h0040_0010,  32'h0,          1, 0, 32'h0040_0010, 32'hAABB_CCDD,  0);
      tbl[14] = mk(0, 1, 0, 32'h0,          32'h1234_5678,  0, 1, 32'h0040_0010, 32'h1234_5678,  0);
      tbl[15] = mk(0, 0, 0, 32'hFFFF_FFFC,  32'h0,          1, 0, 32'hFFFF_FFFC, 32'h1234_5678,  0);
      tbl[16] = mk(0, 0, 0, 32'h0,          32'h0,          1, 0, 32'hFFFF_FFFC, 32'h1234_5678,  0);
      tbl[17] = mk(1, 1, 0, 32'h0,          32'hDEAD_BEEF,  0, 0, 32'h0040_0000, 32'h0,          0);
      tbl[18] = mk(0, 1, 0, 32'h0,          32'hDEAD_BEEF,  1, 0, 32'h0040_0000, 32'h0,          0);
      tbl[19] = mk(0, 1, 0, 32'h0,          32'h0000_0020,  0, 1, 32'h0040_0000, 32'h0000_0020,  0);
      tbl[20] = mk(0, 0, 0, 32'h0040_0006,  32'h0,          1, 0, a20,           32'h0000_0020,  ALIGN);
      tbl[21] = mk(0, 1, 0, 32'h0,          32'h0000_0001,  0, 1, a20,           32'h0000_0001,  ALIGN);
      tbl[22] = mk(0, 0, 0, 32'h0040_0008,  32'h0,          1, 0, 32'h0040_0008, 32'h0000_0001,  ALIGN);

      rst = 1; stall = 0; dir = 0; u_if.ack = 0; u_if.rdata = 0;

      for (int i = 0; i < 23; i++) begin
         rst = tbl[i].rst; u_if.ack = tbl[i].ack; stall = tbl[i].stall;
         dir = tbl[i].dir; u_if.rdata = tbl[i].rdata;
         @(posedge clk); #1;
         check($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_vld, tbl[i].e_addr,
               tbl[i].e_instr, tbl[i].e_mis);
      end

      // Randomized traffic; first two cycles force a clean reset of DUT and model.
      for (int c = 0; c < 3000; c++) begin
         rst        = (c < 2) || ($urandom_range(39) == 0);
         u_if.ack   = $urandom_range(1);
         stall      = $urandom_range(1);
         dir        = $urandom;
         if ($urandom_range(3) != 0) dir[1:0] = 2'b00;
         if ($urandom_range(7) == 0) dir = 32'hFFFF_FFFC;
         u_if.rdata = $urandom;
         @(posedge clk); #1;
         model_edge();
         check($sformatf("rand%0d", c), !m_boot && !m_have, m_have, m_pc, m_instr, m_mis);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
